// File: rtl/branch_resolver.sv
// branch_resolver
//   Resolution end of the 2-bit dynamic branch predictor. Fetch pushes each
//   predicted branch into an in-order in-flight queue. Execute resolves the
//   oldest entry, and this block produces the predictor update pair. On a
//   mispredict it squashes every younger entry, pulses flush with the correct
//   PC, and blocks new predictions for FLUSH_CYCLES cycles.
//
// Ports
//   clk, reset_n                 clock, synchronous active-low reset
//   pred_push/taken/pc/target    prediction from fetch, accepted when pred_ready
//   pred_ready                   queue not full and not flushing
//   ex_valid/taken/target        actual outcome of the oldest in-flight branch
//   upd_valid, upd_taken         registered predictor update (1-cycle latency)
//   flush, redirect_pc           registered mispredict pulse and correct PC
//   underflow_err                sticky: resolve arrived with nothing to resolve
//   branch_cnt, mispred_cnt      wrapping statistic counters
module branch_resolver #(
    parameter int DEPTH        = 4,
    parameter int PC_W         = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             pred_push,
    input  logic             pred_taken,
    input  logic [PC_W-1:0]  pred_pc,
    input  logic [PC_W-1:0]  pred_target,
    output logic             pred_ready,
    input  logic             ex_valid,
    input  logic             ex_taken,
    input  logic [PC_W-1:0]  ex_target,
    output logic             upd_valid,
    output logic             upd_taken,
    output logic             flush,
    output logic [PC_W-1:0]  redirect_pc,
    output logic             underflow_err,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int FC_W  = $clog2(FLUSH_CYCLES + 1);
    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

    typedef struct packed {
        logic            taken;
        logic [PC_W-1:0] pc;
        logic [PC_W-1:0] target;
    } entry_t;

    typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

    entry_t           q [DEPTH];
    entry_t           head;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic [FC_W-1:0]  fcnt;
    state_t           state, state_nxt;
    logic             push_ok, ex_ok, pop, mispredict;

    assign head    = q[rd_ptr];
    assign ex_ok   = (state == RUN) && (count != '0);
    assign pop     = ex_valid && ex_ok;
    assign push_ok = pred_push && pred_ready;
    // Taken/not-taken disagreement, or both taken but to a different target.
    assign mispredict = pop && ((ex_taken != head.taken) ||
                                (ex_taken && (ex_target != head.target)));

    // FSM: state register
    always_ff @(posedge clk) begin
        if (!reset_n) state <= RUN;
        else          state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (mispredict) state_nxt = FLUSH;
            FLUSH:   if (fcnt == FC_W'(1)) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    // FSM: outputs (registered state only, no input paths)
    always_comb begin
        pred_ready = (state == RUN) && (count != FULL);
    end

    // Flush hold-off down-counter
    always_ff @(posedge clk) begin
        if (!reset_n)           fcnt <= '0;
        else if (mispredict)    fcnt <= FC_W'(FLUSH_CYCLES);
        else if (state == FLUSH) fcnt <= fcnt - 1'b1;
    end

    // Queue pointers. A mispredict empties the queue and drops any
    // same-cycle push, since that push came from the wrong path.
    always_ff @(posedge clk) begin
        if (!reset_n || mispredict) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage needs no reset; count gates every read.
    always_ff @(posedge clk) begin
        if (reset_n && push_ok && !mispredict)
            q[wr_ptr] <= '{taken: pred_taken, pc: pred_pc, target: pred_target};
    end

    // Registered update, redirect, error and statistics
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            upd_valid     <= 1'b0;
            upd_taken     <= 1'b0;
            flush         <= 1'b0;
            redirect_pc   <= '0;
            underflow_err <= 1'b0;
            branch_cnt    <= '0;
            mispred_cnt   <= '0;
        end else begin
            upd_valid <= pop;
            if (pop) upd_taken <= ex_taken;
            flush       <= mispredict;
            redirect_pc <= mispredict ? (ex_taken ? ex_target : head.pc + PC_W'(4)) : '0;
            if (ex_valid && !ex_ok) underflow_err <= 1'b1;
            if (pop)        branch_cnt  <= branch_cnt + 1'b1;
            if (mispredict) mispred_cnt <= mispred_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_branch_resolver.sv
module tb_branch_resolver;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        pred_push = 1'b0, pred_taken = 1'b0;
    logic [31:0] pred_pc = '0, pred_target = '0;
    logic        pred_ready;
    logic        ex_valid = 1'b0, ex_taken = 1'b0;
    logic [31:0] ex_target = '0;
    logic        upd_valid, upd_taken, flush, underflow_err;
    logic [31:0] redirect_pc;
    logic [15:0] branch_cnt, mispred_cnt;

    branch_resolver #(.DEPTH(4), .PC_W(32), .FLUSH_CYCLES(2), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .pred_push(pred_push), .pred_taken(pred_taken), .pred_pc(pred_pc),
        .pred_target(pred_target), .pred_ready(pred_ready),
        .ex_valid(ex_valid), .ex_taken(ex_taken), .ex_target(ex_target),
        .upd_valid(upd_valid), .upd_taken(upd_taken), .flush(flush),
        .redirect_pc(redirect_pc), .underflow_err(underflow_err),
        .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    // One record per clock: inputs driven before the edge, outputs expected after it.
    typedef struct {
        string       name;
        logic        rst_n, push, pt;
        logic [31:0] ppc, ptgt;
        logic        exv, ext;
        logic [31:0] extgt;
        logic        rdy, uv, ut, fl;
        logic [31:0] rpc;
        logic        uf;
        logic [15:0] bc, mc;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic v(input string name, input logic rst_n, push, pt,
                     input logic [31:0] ppc, ptgt, input logic exv, ext,
                     input logic [31:0] extgt, input logic rdy, uv, ut, fl,
                     input logic [31:0] rpc, input logic uf, input logic [15:0] bc, mc);
        vec_t r;
        r.name = name; r.rst_n = rst_n; r.push = push; r.pt = pt; r.ppc = ppc; r.ptgt = ptgt;
        r.exv = exv; r.ext = ext; r.extgt = extgt; r.rdy = rdy; r.uv = uv; r.ut = ut;
        r.fl = fl; r.rpc = rpc; r.uf = uf; r.bc = bc; r.mc = mc;
        vecs.push_back(r);
    endtask

    task automatic chk(input string name, input string field, input logic [31:0] act, exp);
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s.%s: got 0x%0h, want 0x%0h", name, field, act, exp);
        end
    endtask

    task automatic drive(input vec_t r);
        reset_n = r.rst_n; pred_push = r.push; pred_taken = r.pt; pred_pc = r.ppc;
        pred_target = r.ptgt; ex_valid = r.exv; ex_taken = r.ext; ex_target = r.extgt;
    endtask

    task automatic idle();
        pred_push = 1'b0; ex_valid = 1'b0;
    endtask

    initial begin
        vec_t e;
        int   n;
        //         name         rst push pt ppc     ptgt    exv ext extgt   rdy uv ut fl rpc    uf bc  mc
        v("reset",        0, 0, 0, 32'h0,   32'h0,   0, 0, 32'h0,   1, 0, 0, 0, 32'h0,   0, 0,  0);
        v("push100",      1, 1, 1, 32'h100, 32'h180, 0, 0, 32'h0,   1, 0, 0, 0, 32'h0,   0, 0,  0);
        v("hit180",       1, 0, 0, 32'h0,   32'h0,   1, 1, 32'h180, 1, 1, 1, 0, 32'h0,   0, 1,  0);
        v("idle_hold",    1, 0, 0, 32'h0,   32'h0,   0, 0, 32'h0,   1, 0, 1, 0, 32'h0,   0, 1,  0);
        v("push200nt",    1, 1, 0, 32'h200, 32'h208, 0, 0, 32'h0,   1, 0, 1, 0, 32'h0,   0, 1,  0);
        v("miss240",      1, 0, 0, 32'h0,   32'h0,   1, 1, 32'h240, 0, 1, 1, 1, 32'h240, 0, 2,  1);
        v("flush_drop",   1, 1, 1, 32'h999, 32'h9a0, 0, 0, 32'h0,   0, 0, 1, 0, 32'h0,   0, 2,  1);
        v("flush_end",    1, 0, 0, 32'h0,   32'h0,   0, 0, 32'h0,   1, 0, 1, 0, 32'h0,   0, 2,  1);
        v("push300",      1, 1, 1, 32'h300, 32'h340, 0, 0, 32'h0,   1, 0, 1, 0, 32'h0,   0, 2,  1);
        v("push310",      1, 1, 1, 32'h310, 32'h350, 0, 0, 32'h0,   1, 0, 1, 0, 32'h0,   0, 2,  1);
        v("push320",      1, 1, 1, 32'h320, 32'h360, 0, 0, 32'h0,   1, 0, 1, 0, 32'h0,   0, 2,  1);
        v("miss_nt304",   1, 1, 1, 32'h777, 32'h780, 1, 0, 32'h0,   0, 1, 0, 1, 32'h304, 0, 3,  2);
        v("flush2a",      1, 0, 0, 32'h0,   32'h0,   0, 0, 32'h0,   0, 0, 0, 0, 32'h0,   0, 3,  2);
        v("flush2b",      1, 0, 0, 32'h0,   32'h0,   0, 0, 32'h0,   1, 0, 0, 0, 32'h0,   0, 3,  2);
        v("underflow",    1, 0, 0, 32'h0,   32'h0,   1, 1, 32'h0,   1, 0, 0, 0, 32'h0,   1, 3,  2);
        v("fill400",      1, 1, 1, 32'h400, 32'h410, 0, 0, 32'h0,   1, 0, 0, 0, 32'h0,   1, 3,  2);
        v("fill404",      1, 1, 0, 32'h404, 32'h0,   0, 0, 32'h0,   1, 0, 0, 0, 32'h0,   1, 3,  2);
        v("fill408",      1, 1, 1, 32'h408, 32'h418, 0, 0, 32'h0,   1, 0, 0, 0, 32'h0,   1, 3,  2);
        v("fill40c_full", 1, 1, 0, 32'h40c, 32'h0,   0, 0, 32'h0,   0, 0, 0, 0, 32'h0,   1, 3,  2);
        v("drop5th",      1, 1, 1, 32'h4f0, 32'h4f8, 0, 0, 32'h0,   0, 0, 0, 0, 32'h0,   1, 3,  2);
        v("pop400",       1, 0, 0, 32'h0,   32'h0,   1, 1, 32'h410, 1, 1, 1, 0, 32'h0,   1, 4,  2);
        v("push_pop404",  1, 1, 1, 32'h420, 32'h430, 1, 0, 32'h0,   1, 1, 0, 0, 32'h0,   1, 5,  2);
        v("refill424",    1, 1, 0, 32'h424, 32'h0,   0, 0, 32'h0,   0, 0, 0, 0, 32'h0,   1, 5,  2);
        v("pop408",       1, 0, 0, 32'h0,   32'h0,   1, 1, 32'h418, 1, 1, 1, 0, 32'h0,   1, 6,  2);
        v("pop40c",       1, 0, 0, 32'h0,   32'h0,   1, 0, 32'h0,   1, 1, 0, 0, 32'h0,   1, 7,  2);
        v("pop420_wrap",  1, 0, 0, 32'h0,   32'h0,   1, 1, 32'h430, 1, 1, 1, 0, 32'h0,   1, 8,  2);
        v("pop424",       1, 0, 0, 32'h0,   32'h0,   1, 0, 32'h0,   1, 1, 0, 0, 32'h0,   1, 9,  2);
        v("push_t500",    1, 1, 1, 32'h4e0, 32'h500, 0, 0, 32'h0,   1, 0, 0, 0, 32'h0,   1, 9,  2);
        v("miss_tgt504",  1, 0, 0, 32'h0,   32'h0,   1, 1, 32'h504, 0, 1, 1, 1, 32'h504, 1, 10, 3);
        v("ex_in_flush",  1, 0, 0, 32'h0,   32'h0,   1, 1, 32'h0,   0, 0, 1, 0, 32'h0,   1, 10, 3);
        v("reset_flush",  0, 0, 0, 32'h0,   32'h0,   0, 0, 32'h0,   1, 0, 0, 0, 32'h0,   0, 0,  0);
        v("post_reset",   1, 0, 0, 32'h0,   32'h0,   0, 0, 32'h0,   1, 0, 0, 0, 32'h0,   0, 0,  0);

        #1;
        foreach (vecs[i]) begin
            drive(vecs[i]);
            exp_q.push_back(vecs[i]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_vec++;
            chk(e.name, "pred_ready",    32'(pred_ready),    32'(e.rdy));
            chk(e.name, "upd_valid",     32'(upd_valid),     32'(e.uv));
            chk(e.name, "upd_taken",     32'(upd_taken),     32'(e.ut));
            chk(e.name, "flush",         32'(flush),         32'(e.fl));
            chk(e.name, "redirect_pc",   redirect_pc,        e.rpc);
            chk(e.name, "underflow_err", 32'(underflow_err), 32'(e.uf));
            chk(e.name, "branch_cnt",    32'(branch_cnt),    32'(e.bc));
            chk(e.name, "mispred_cnt",   32'(mispred_cnt),   32'(e.mc));
        end

        // Hand sequence: count how long pred_ready stays low after a mispredict.
        idle();
        pred_push = 1'b1; pred_taken = 1'b0; pred_pc = 32'h600;
        @(posedge clk); #1;
        idle();
        ex_valid = 1'b1; ex_taken = 1'b1; ex_target = 32'h640;
        @(posedge clk); #1;
        idle();
        n_vec++;
        chk("hs_miss", "flush",       32'(flush), 32'h1);
        chk("hs_miss", "redirect_pc", redirect_pc, 32'h640);
        chk("hs_miss", "mispred_cnt", 32'(mispred_cnt), 32'h1);
        n = 0;
        while (!pred_ready && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        n_vec++;
        chk("hs_block_cycles", "cycles", 32'(n), 32'd2);
        chk("hs_block_cycles", "flush",  32'(flush), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
